// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin bus arbiter with bounded hold and 2:1 data selector
module bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  selector,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    localparam int             CW       = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      rst_sync;
    logic            run;
    logic            last;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_nxt;

    // Reset asserts asynchronously but releases through two flops, so no grant
    // can be issued until the release has settled inside the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        case (state)
            IDLE: begin
                if (run) begin
                    if (req0 && req1) begin
                        state_nxt = last ? GRANT0 : GRANT1;
                    end else if (req0) begin
                        state_nxt = GRANT0;
                    end else if (req1) begin
                        state_nxt = GRANT1;
                    end
                end
            end
            GRANT0: begin
                if (!req0) begin
                    state_nxt = req1 ? GRANT1 : IDLE;
                end else if (req1 && (hold_cnt == HOLD_MAX)) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    state_nxt = req0 ? GRANT0 : IDLE;
                end else if (req0 && (hold_cnt == HOLD_MAX)) begin
                    state_nxt = GRANT0;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Counter only advances while the same grant is kept; saturation lets an
        // uncontended holder keep the bus forever.
        if ((state_nxt == state) && (state != IDLE)) begin
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (state_nxt == GRANT0) begin
                last <= 1'b0;
            end else if (state_nxt == GRANT1) begin
                last <= 1'b1;
            end
        end
    end

    assign gnt0      = (state == GRANT0);
    assign gnt1      = (state == GRANT1);
    assign selector  = (state == GRANT1);
    assign out_data  = selector ? data1 : data0;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          reset_n;
    logic          req0;
    logic          req1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          gnt0;
    logic          gnt1;
    logic          selector;
    logic [DW-1:0] out_data;
    logic          out_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bus_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .selector  (selector),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0    = 1'b0;
        req1    = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        req0    = 1'b1;
        req1    = 1'b1;
        data0   = 32'h0000_D000;
        data1   = 32'h0000_D001;
        reset_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({gnt0, gnt1, selector, out_valid} !== 4'b0000) begin
            $display("FAIL reset_outputs: gnt0/gnt1/sel/valid=%b required 0000", {gnt0, gnt1, selector, out_valid});
        end else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h0000_D000) begin
            $display("FAIL reset_data: out_data=%h required %h", out_data, 32'h0000_D000);
        end else pass_cnt++;
        req0 = 1'b0;
        req1 = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        data0 = 32'h1111_0000;
        data1 = 32'h2222_0000;
        req1  = 1'b1;
        tick();
        total_cnt++;
        if (gnt1 !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL midrst_pre: gnt1=%b valid=%b required 1 1", gnt1, out_valid);
        end else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({gnt1, selector, out_valid} !== 3'b000) begin
            $display("FAIL midrst_async: gnt1/sel/valid=%b required 000", {gnt1, selector, out_valid});
        end else pass_cnt++;
        total_cnt++;
        if (out_data !== 32'h1111_0000) begin
            $display("FAIL midrst_data: out_data=%h required %h", out_data, 32'h1111_0000);
        end else pass_cnt++;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if ({gnt0, gnt1} !== 2'b00) begin
            $display("FAIL midrst_early: gnt0/gnt1=%b required 00 one edge after release", {gnt0, gnt1});
        end else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            $display("FAIL midrst_first: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end else pass_cnt++;
    endtask

    task automatic test_single();
        int vcnt;
        do_reset();
        data0 = 32'hA5A5_0001;
        req0  = 1'b1;
        vcnt  = 0;
        total_cnt++;
        if (gnt0 !== 1'b0 || out_valid !== 1'b0) begin
            $display("FAIL single_pre: gnt0=%b valid=%b required 0 0", gnt0, out_valid);
        end else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid === 1'b1) vcnt++;
            total_cnt++;
            if (gnt0 !== 1'b1 || out_data !== 32'hA5A5_0001) begin
                $display("FAIL single_grant[%0d]: gnt0=%b data=%h required 1 %h", i, gnt0, out_data, 32'hA5A5_0001);
            end else pass_cnt++;
        end
        req0 = 1'b0;
        #1;
        if (out_valid === 1'b1) vcnt++;
        tick();
        if (out_valid === 1'b1) vcnt++;
        total_cnt++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            $display("FAIL single_idle: gnt0=%b gnt1=%b required 0 0", gnt0, gnt1);
        end else pass_cnt++;
        tick();
        if (out_valid === 1'b1) vcnt++;
        total_cnt++;
        if (vcnt !== 5) begin
            $display("FAIL single_count: valid cycles=%0d required 5", vcnt);
        end else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1;
            req1 = 1'b1;
            tick();
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
            total_cnt++;
            if ({gnt0, gnt1} !== exp) begin
                $display("FAIL rr[%0d]: gnt0/gnt1=%b required %b", i, {gnt0, gnt1}, exp);
            end else pass_cnt++;
            req0 = 1'b0;
            req1 = 1'b0;
            tick();
        end
    endtask

    task automatic test_forced_rotation();
        logic e0;
        int   vbad;
        do_reset();
        data0 = 32'h0000_AAAA;
        data1 = 32'h0000_BBBB;
        req0  = 1'b1;
        req1  = 1'b1;
        vbad  = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            e0 = ((k / 4) % 2 == 0);
            if (out_valid !== 1'b1) vbad++;
            total_cnt++;
            if (gnt0 !== e0 || gnt1 !== !e0 || selector !== !e0) begin
                $display("FAIL rot[%0d]: gnt0=%b gnt1=%b sel=%b required %b %b %b", k, gnt0, gnt1, selector, e0, !e0, !e0);
            end else pass_cnt++;
        end
        total_cnt++;
        if (vbad !== 0) begin
            $display("FAIL rot_valid: cycles without valid=%0d required 0", vbad);
        end else pass_cnt++;
    endtask

    task automatic test_handoff();
        do_reset();
        data0 = 32'hC0C0_0000;
        data1 = 32'hD1D1_1111;
        req0  = 1'b1;
        tick();
        req1 = 1'b1;
        tick();
        total_cnt++;
        if (gnt0 !== 1'b1 || out_data !== 32'hC0C0_0000) begin
            $display("FAIL handoff_pre: gnt0=%b data=%h required 1 %h", gnt0, out_data, 32'hC0C0_0000);
        end else pass_cnt++;
        req0 = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0) begin
            $display("FAIL handoff_drop: valid=%b required 0", out_valid);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hD1D1_1111) begin
            $display("FAIL handoff_next: gnt1=%b gnt0=%b valid=%b data=%h required 1 0 1 %h", gnt1, gnt0, out_valid, out_data, 32'hD1D1_1111);
        end else pass_cnt++;
    endtask

    task automatic test_uncontended();
        int bad;
        do_reset();
        req1 = 1'b1;
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        total_cnt++;
        if (bad !== 0) begin
            $display("FAIL hold_gnt: cycles without gnt1=%0d required 0", bad);
        end else pass_cnt++;
        total_cnt++;
        if (dut.hold_cnt !== 2'd3) begin
            $display("FAIL hold_sat: hold_cnt=%0d required 3", dut.hold_cnt);
        end else pass_cnt++;
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        data0   = '0;
        data1   = '0;
        test_reset();
        test_reset_mid_grant();
        test_single();
        test_round_robin();
        test_forced_rotation();
        test_handoff();
        test_uncontended();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter that shares one data path, built from a 2:1 selector, between requester 0 and requester 1.
- Typical pairing: CPU write port and graphics/sprite engine contending for one memory write bus.
- Grants in round-robin order, with a bounded hold time so neither side can starve the other.
- Drives the selector of the 2:1 data path and presents the selected word with a valid flag.

Parameters:
- DATA_WIDTH, 32, width of each requester's data word and of out_data.
- MAX_HOLD, 16, maximum consecutive granted cycles while the other side is requesting; legal range 2..256.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 requests the bus; held high for as long as it wants to transfer.
- req1  input  1  requester 1 requests the bus.
- data0  input  DATA_WIDTH  requester 0 data word.
- data1  input  DATA_WIDTH  requester 1 data word.
- gnt0  output  1  registered; requester 0 owns the bus.
- gnt1  output  1  registered; requester 1 owns the bus.
- selector  output  1  registered; 0 selects data0, 1 selects data1; equals gnt1.
- out_data  output  DATA_WIDTH  combinational; data0 when selector=0, data1 when selector=1.
- out_valid  output  1  combinational; (gnt0 & req0) | (gnt1 & req1).

Behaviour:
- State machine: IDLE, GRANT0, GRANT1.
  - gnt0 = (state==GRANT0); gnt1 = (state==GRANT1); selector = (state==GRANT1).
  - gnt0 and gnt1 are never high together.
- Internal registers:
  - last: last requester served; reset value 1, so requester 0 wins the first contention.
  - hold_cnt: width ceil(log2(MAX_HOLD)), counts cycles in the current grant.
- Reset (async assert, any state, including mid-transfer):
  - state=IDLE, gnt0=gnt1=0, selector=0, last=1, hold_cnt=0.
  - out_valid=0 immediately; out_data shows data0.
- Deassertion is synchronised internally. The first grant can occur no earlier than the second rising edge after reset_n rises.
- Latency: a request sampled high at edge N yields a grant visible after edge N. Grant takes effect one cycle after request; the first transfer completes on edge N+1.
- IDLE transitions:
  - only req0 -> GRANT0.
  - only req1 -> GRANT1.
  - both -> GRANT of the side != last.
  - neither -> stay IDLE.
- GRANTx (x=granted, y=other), evaluated each edge:
  - req_x=0 and req_y=1 -> GRANTy (direct hand-off, no idle bubble).
  - req_x=0 and req_y=0 -> IDLE.
  - req_x=1, req_y=1, hold_cnt==MAX_HOLD-1 -> GRANTy (forced rotation).
  - otherwise stay in GRANTx.
- hold_cnt rules:
  - Cleared to 0 on every entry into GRANT0/GRANT1 and in IDLE.
  - While staying in GRANTx it increments, saturating at MAX_HOLD-1.
  - With no competing request, the holder keeps the bus indefinitely at saturation.
- last is updated to x on every entry into GRANTx.
- Transfer accounting: one word moves per cycle in which out_valid=1. A requester that drops req while granted loses the grant at the next edge. Its final word was the last cycle with its req high.
- A requester may raise req in any cycle; no minimum or maximum request length.
- Requesters must hold data stable while req is high.

Test Plan:
- Reset mid-grant:
  - Stimulus: assert reset_n=0 while in GRANT1 with req1=1.
  - Required: gnt1, selector and out_valid drop to 0 without a clock edge.
  - After release with req0=req1=1: first grant goes to gnt0.
- Single requester:
  - Stimulus: req0=1 for 5 cycles, data0=32'hA5A5_0001.
  - Required: gnt0 high one edge after req0. out_valid=1 for exactly 5 cycles with out_data=32'hA5A5_0001.
  - Required: state returns to IDLE the edge after req0 falls.
- Round-robin alternation:
  - Stimulus: req0 and req1 each pulsed 1 cycle, repeatedly and simultaneously, from IDLE.
  - Required: grants alternate 0,1,0,1; no requester is granted twice in a row.
- Forced rotation (MAX_HOLD=4):
  - Stimulus: req0 and req1 held high continuously.
  - Required: gnt0 for exactly 4 cycles, then gnt1 for 4, repeating.
  - Required: selector toggles every 4 cycles; out_valid stays continuously 1.
- Hand-off without bubble:
  - Stimulus: in GRANT0, drop req0 while req1=1.
  - Required: gnt1 asserted at the next edge with no IDLE cycle between; out_data switches to data1.
- Uncontended hold:
  - Stimulus: req1 held 100 cycles, req0=0.
  - Required: gnt1 held for all 100 cycles; hold_cnt saturates at MAX_HOLD-1 with no rotation.
